// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_pkg
// Description : Shared types and constants for the PHI0 clock sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_HIGH = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SPD_X1 = 2'b00;
    localparam logic [1:0] SPD_X2 = 2'b01;
    localparam logic [1:0] SPD_X4 = 2'b10;
    localparam logic [1:0] SPD_X8 = 2'b11;

    // True when a CNT_W-bit counter can hold every load the sequencer issues.
    function automatic bit cnt_w_ok(input int cnt_w, input int low_t,
                                    input int high_t, input int wait_t);
        longint max_base;
        longint need_phase;
        longint need_wait;
        longint cap;
        max_base   = (low_t > high_t) ? longint'(low_t) : longint'(high_t);
        need_phase = (max_base << 3) - 1;
        need_wait  = longint'(wait_t) - 1;
        cap        = (longint'(1) << cnt_w) - 1;
        return (low_t >= 1) && (high_t >= 1) && (wait_t >= 0) &&
               (need_phase <= cap) && (need_wait <= cap);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_sync.sv
`default_nettype none
// ============================================================================
// Module      : step_sync
// Description : Two-flop synchronizer with rising-edge pulse for the STEP button.
// Revision    : 1.0  initial release
// ============================================================================
module step_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_step,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_step;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_ctrl
// Description : 65C02 PHI0 sequencer with speed scaling and slow-access stretch.
//               Optional single-step mode: define CPU_CLK_SINGLE_STEP_EN.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int LOW_TICKS  = 7,
    parameter int HIGH_TICKS = 7,
    parameter int WAIT_TICKS = 14,
    parameter int CNT_W      = 8
) (
    input  logic       CLK_SRC,
    input  logic       RESET_N,
    input  logic [1:0] SPEED_SEL,
    input  logic       SLOW_CS,
`ifdef CPU_CLK_SINGLE_STEP_EN
    input  logic       STEP_MODE,
    input  logic       STEP,
`endif
    output logic       PHI0,
    output logic       PHI2_RISE,
    output logic       STRETCHING
);

    generate
        if (!cnt_w_ok(CNT_W, LOW_TICKS, HIGH_TICKS, WAIT_TICKS)) begin : g_cnt_w_chk
            $error("cpu_clk_ctrl: CNT_W too narrow or tick parameters out of range");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] phase_load(input int base, input logic [1:0] sel);
        int scaled;
        case (sel)
            SPD_X1: scaled = base;
            SPD_X2: scaled = base * 2;
            SPD_X4: scaled = base * 4;
            SPD_X8: scaled = base * 8;
        endcase
        return CNT_W'(scaled - 1);
    endfunction

    localparam logic [CNT_W-1:0] c_low_rst   = CNT_W'(LOW_TICKS - 1);
    localparam logic [CNT_W-1:0] c_wait_load = CNT_W'((WAIT_TICKS > 0) ? WAIT_TICKS - 1 : 0);
    localparam bit               c_wait_en   = (WAIT_TICKS > 0);

    state_t           r_state;
    state_t           w_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [1:0]       r_sh;
    logic [1:0]       w_sh;
    logic             r_slow_pend;
    logic             w_slow_pend;
    logic             r_phi0;
    logic             w_phi0;
    logic             r_rise;
    logic             w_rise;
    logic             r_stretch;
    logic             w_stretch;
    logic             w_cnt_zero;
    logic             w_advance;

`ifdef CPU_CLK_SINGLE_STEP_EN
    logic w_step_rise;

    step_sync u_step_sync (
        .clk    (CLK_SRC),
        .rst_n  (RESET_N),
        .i_step (STEP),
        .o_rise (w_step_rise)
    );

    // Edges arriving outside the hold point are simply never consumed.
    assign w_advance = !STEP_MODE || w_step_rise;
`else
    assign w_advance = 1'b1;
`endif

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_LOW;
            r_cnt       <= c_low_rst;
            r_sh        <= SPD_X1;
            r_slow_pend <= 1'b0;
            r_phi0      <= 1'b0;
            r_rise      <= 1'b0;
            r_stretch   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_sh        <= w_sh;
            r_slow_pend <= w_slow_pend;
            r_phi0      <= w_phi0;
            r_rise      <= w_rise;
            r_stretch   <= w_stretch;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_sh        = r_sh;
        w_slow_pend = r_slow_pend;
        w_phi0      = r_phi0;
        w_rise      = 1'b0;
        w_stretch   = r_stretch;
        case (r_state)
            S_LOW: begin
                if (!w_cnt_zero) begin
                    w_cnt = r_cnt - 1'b1;
                end else if (w_advance) begin
                    w_state     = S_HIGH;
                    w_cnt       = phase_load(HIGH_TICKS, r_sh);
                    w_slow_pend = SLOW_CS;
                    w_phi0      = 1'b1;
                    w_rise      = 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_cnt_zero) begin
                    w_cnt = r_cnt - 1'b1;
                end else if (r_slow_pend && c_wait_en) begin
                    w_state   = S_WAIT;
                    w_cnt     = c_wait_load;
                    w_stretch = 1'b1;
                end else begin
                    // New speed is only adopted here so no phase is ever cut short.
                    w_state = S_LOW;
                    w_sh    = SPEED_SEL;
                    w_cnt   = phase_load(LOW_TICKS, SPEED_SEL);
                    w_phi0  = 1'b0;
                end
            end
            S_WAIT: begin
                if (!w_cnt_zero) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_state   = S_LOW;
                    w_sh      = SPEED_SEL;
                    w_cnt     = phase_load(LOW_TICKS, SPEED_SEL);
                    w_phi0    = 1'b0;
                    w_stretch = 1'b0;
                end
            end
            default: begin
                w_state   = S_LOW;
                w_cnt     = phase_load(LOW_TICKS, r_sh);
                w_phi0    = 1'b0;
                w_stretch = 1'b0;
            end
        endcase
    end

    assign PHI0       = r_phi0;
    assign PHI2_RISE  = r_rise;
    assign STRETCHING = r_stretch;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_clk_ctrl
// Description : Scoreboard bench for cpu_clk_ctrl phase lengths and flags.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_clk_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] spd;
    logic       slow;
    logic       phi0;
    logic       rise;
    logic       str;
`ifdef CPU_CLK_SINGLE_STEP_EN
    logic       step_mode;
    logic       step;
`endif

    typedef struct {
        logic lvl;
        int   len;
        int   str;
        int   rise;
    } phase_t;

    phase_t sb_q[$];
    int     n_checks;
    int     n_fail;
    logic   mon_en;

    cpu_clk_ctrl #(
        .LOW_TICKS  (7),
        .HIGH_TICKS (7),
        .WAIT_TICKS (14),
        .CNT_W      (8)
    ) dut (
        .CLK_SRC    (clk),
        .RESET_N    (rst_n),
        .SPEED_SEL  (spd),
        .SLOW_CS    (slow),
`ifdef CPU_CLK_SINGLE_STEP_EN
        .STEP_MODE  (step_mode),
        .STEP       (step),
`endif
        .PHI0       (phi0),
        .PHI2_RISE  (rise),
        .STRETCHING (str)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_phase(input logic lvl, input int len, input int s, input int r);
        phase_t p;
        p.lvl  = lvl;
        p.len  = len;
        p.str  = s;
        p.rise = r;
        sb_q.push_back(p);
    endtask

    // A stretched cycle keeps its nominal high length plus an unscaled wait.
    task automatic push_cycle(input int lo, input int hi, input int wt);
        push_phase(1'b0, lo, 0, 0);
        push_phase(1'b1, hi + wt, wt, 1);
    endtask

    task automatic run_monitor();
        logic   prev;
        int     run;
        int     n_str;
        int     n_rise;
        phase_t e;
        prev   = 1'b0;
        run    = 0;
        n_str  = 0;
        n_rise = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev   = 1'b0;
                run    = 0;
                n_str  = 0;
                n_rise = 0;
            end else if (phi0 === prev) begin
                run    = run + 1;
                n_str  = n_str + int'(str);
                n_rise = n_rise + int'(rise);
            end else begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected_phase_len", run, -1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("phase_level", int'(prev), int'(e.lvl));
                    check_val(prev ? "high_len" : "low_len", run, e.len);
                    check_val("stretch_ticks", n_str, e.str);
                    check_val("phi2_rise_count", n_rise, e.rise);
                end
                prev   = phi0;
                run    = 1;
                n_str  = int'(str);
                n_rise = int'(rise);
            end
        end
    endtask

    task automatic wait_edge(input logic lvl);
        int n;
        n = 0;
        while (phi0 === lvl && n < 600) begin
            @(negedge clk);
            n++;
        end
        while (phi0 !== lvl && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check_val("wait_edge_timeout", 0, 1);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        spd      = 2'b00;
        slow     = 1'b0;
`ifdef CPU_CLK_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        fork
            run_monitor();
        join_none

        repeat (3) @(negedge clk);
        check_val("reset_phi0", int'(phi0), 0);
        check_val("reset_phi2_rise", int'(rise), 0);
        check_val("reset_stretching", int'(str), 0);

        // Nominal cycles after reset release
        repeat (3) push_cycle(7, 7, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) wait_edge(1'b0);

        // Slow access held
        slow = 1'b1;
        repeat (2) push_cycle(7, 7, 14);
        repeat (2) wait_edge(1'b0);
        slow = 1'b0;

        // Slow select only during the high phase
        repeat (2) push_cycle(7, 7, 0);
        repeat (2) begin
            wait_edge(1'b1);
            repeat (2) @(negedge clk);
            slow = 1'b1;
            wait_edge(1'b0);
            slow = 1'b0;
        end

        // Speed changes mid high phase, plus one stretched x2 cycle
        push_cycle(7, 7, 0);
        wait_edge(1'b1);
        repeat (3) @(negedge clk);
        spd = 2'b11;
        push_cycle(56, 56, 0);
        wait_edge(1'b0);
        wait_edge(1'b1);
        spd = 2'b01;
        push_cycle(14, 14, 14);
        wait_edge(1'b0);
        slow = 1'b1;
        wait_edge(1'b1);
        slow = 1'b0;
        spd = 2'b10;
        push_cycle(28, 28, 0);
        wait_edge(1'b0);
        wait_edge(1'b1);
        spd = 2'b00;
        push_cycle(7, 7, 0);
        wait_edge(1'b0);
        wait_edge(1'b0);

        // Asynchronous reset while stretching
        #1 mon_en = 1'b0;
        check_val("sb_drain_before_reset", sb_q.size(), 0);
        slow = 1'b1;
        n = 0;
        while (str !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("stretch_before_reset", int'(str), 1);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_reset_phi0", int'(phi0), 0);
        check_val("async_reset_stretching", int'(str), 0);
        check_val("async_reset_phi2_rise", int'(rise), 0);
        slow = 1'b0;
        repeat (3) @(negedge clk);
        repeat (2) push_cycle(7, 7, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) wait_edge(1'b0);

        check_val("sb_drain_final", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
